// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared single-port memory.
// The slave modport is the arbiter's view. The master modport is the requester/memory side.
interface mem_arbiter_if #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 14
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;

    logic [DW-1:0] rdata;

    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_dout,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata, mem_cs, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_dout,
        output gnt0, rvalid0, gnt1, rvalid1, rdata, mem_cs, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with a bounded burst in front of a shared single-port memory.
// Read data is routed back to the requester that issued it through a tag pipeline.
module mem_arbiter #(
    parameter int unsigned AW        = 6,
    parameter int unsigned DW        = 14,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rstn,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned    CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RD_LAT-1:0]   tag_v_q, tag_id_q;
    logic [DW-1:0]       rdata_q, rdata_d;

    logic own0, own1, own_req, other_req, access, sel_we, burst_end, rd_fire;

    always_comb begin
        own0      = (state_q == StOwn0);
        own1      = (state_q == StOwn1);
        own_req   = own1 ? bus.req1 : bus.req0;
        other_req = own1 ? bus.req0 : bus.req1;
        access    = (own0 | own1) & own_req;
        sel_we    = own1 ? bus.we1 : bus.we0;
        burst_end = access && (cnt_q == CNT_MAX) && other_req;

        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                // With both requesting, the one that did not own mem last wins.
                if (bus.req0 && (!bus.req1 || last_q)) state_d = StOwn0;
                else if (bus.req1)                     state_d = StOwn1;
            end
            StOwn0, StOwn1: begin
                if (!own_req || burst_end) begin
                    state_d = other_req ? (own1 ? StOwn0 : StOwn1) : StIdle;
                    last_d  = own1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Count saturates so an unbounded solo burst still yields once the other side asks.
        if (state_d != state_q)               cnt_d = '0;
        else if (access && cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
        else                                  cnt_d = cnt_q;

        rd_fire = tag_v_q[RD_LAT-1];
        rdata_d = rd_fire ? bus.mem_dout : rdata_q;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            tag_v_q[0]  <= access & ~sel_we;
            tag_id_q[0] <= own1;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
            rdata_q <= rdata_d;
        end
    end

    assign bus.gnt0     = own0;
    assign bus.gnt1     = own1;
    assign bus.mem_cs   = access;
    assign bus.mem_we   = access & sel_we;
    assign bus.mem_addr = own1 ? bus.addr1 : bus.addr0;
    assign bus.mem_din  = own1 ? bus.wdata1 : bus.wdata0;
    assign bus.rvalid0  = rd_fire & ~tag_id_q[RD_LAT-1];
    assign bus.rvalid1  = rd_fire & tag_id_q[RD_LAT-1];
    assign bus.rdata    = rdata_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural 64x14 memory, requester tasks and a
// scoreboard of expected read returns checked by an independent monitor.
module tb_mem_arbiter;
    logic clk;
    logic rstn;

    mem_arbiter_if #(.AW(6), .DW(14)) bus ();

    mem_arbiter #(.AW(6), .DW(14), .MAX_BURST(4), .RD_LAT(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic        id;
        logic [13:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   acc_cyc[2];

    logic [13:0] mem [64];
    logic        loaded = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] init_val(input int i);
        case (i)
            0:       return 14'h0111;
            1:       return 14'h0222;
            2:       return 14'h0333;
            3:       return 14'h3A3C;
            5:       return 14'h1ABC;
            9:       return 14'h0999;
            default: return 14'(i * 3);
        endcase
    endfunction

    // Single-port memory, one-cycle read latency.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (bus.mem_cs) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
            else            bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (bus.rvalid0 || bus.rvalid1) begin
            check("rvalid_onehot", {31'b0, bus.rvalid0 & bus.rvalid1}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_rvalid: rvalid0=%b rvalid1=%b, nothing pending",
                         bus.rvalid0, bus.rvalid1);
            end else begin
                mon_e = sb.pop_front();
                check("rvalid_id", {31'b0, bus.rvalid1}, {31'b0, mon_e.id});
                check("rdata", {18'b0, bus.rdata}, {18'b0, mon_e.data});
            end
        end
    end

    // Hold the request until it is granted, then advance just after that edge.
    task automatic do_access(input bit id, input bit we, input logic [5:0] a,
                             input logic [13:0] d, input logic [13:0] exp_rd);
        bit done = 1'b0;
        if (id) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (id ? bus.gnt1 : bus.gnt0) begin
                if (!we) sb.push_back('{id: id, data: exp_rd});
                acc_cyc[id] = cyc;
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            $display("FAIL grant_timeout: requester %0d got no grant within 50 cycles", id);
        end
    endtask

    initial begin
        rstn = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'h20; bus.wdata0 = 14'h0AAA;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'h21; bus.wdata1 = 14'h0555;

        // T1: reset held with both requesting
        repeat (3) @(negedge clk);
        check("reset_gnt0",    {31'b0, bus.gnt0},    32'd0);
        check("reset_gnt1",    {31'b0, bus.gnt1},    32'd0);
        check("reset_mem_cs",  {31'b0, bus.mem_cs},  32'd0);
        check("reset_rvalid0", {31'b0, bus.rvalid0}, 32'd0);
        check("reset_rvalid1", {31'b0, bus.rvalid1}, 32'd0);

        // T3: fairness from reset, 4 cycles per owner, requester 0 first, no gaps
        rstn = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("fair_gnt0_c%0d", k), {31'b0, bus.gnt0},
                  {31'b0, (((k - 1) / 4) % 2) == 0});
            check($sformatf("fair_gnt1_c%0d", k), {31'b0, bus.gnt1},
                  {31'b0, (((k - 1) / 4) % 2) == 1});
            check($sformatf("fair_cs_c%0d", k), {31'b0, bus.mem_cs}, 32'd1);
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // T2: single read of addr 5
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'h05;
        sb.push_back('{id: 1'b0, data: 14'h1ABC});
        @(negedge clk);
        check("t2_gnt_latency", {31'b0, bus.gnt0}, 32'd0);
        @(negedge clk);
        check("t2_gnt0",     {31'b0, bus.gnt0},     32'd1);
        check("t2_cs",       {31'b0, bus.mem_cs},   32'd1);
        check("t2_we",       {31'b0, bus.mem_we},   32'd0);
        check("t2_addr",     {26'b0, bus.mem_addr}, 32'h05);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        @(negedge clk);
        check("t2_rvalid0",  {31'b0, bus.rvalid0},  32'd1);
        check("t2_rvalid1",  {31'b0, bus.rvalid1},  32'd0);
        check("t2_rdata",    {18'b0, bus.rdata},    32'h1ABC);
        repeat (3) @(posedge clk);
        #1;

        // T4: addr 3 is requester 0's last burst access, requester 1 reads addr 9 next
        fork
            begin
                do_access(1'b0, 1'b0, 6'h00, 14'h0, 14'h0111);
                do_access(1'b0, 1'b0, 6'h01, 14'h0, 14'h0222);
                do_access(1'b0, 1'b0, 6'h02, 14'h0, 14'h0333);
                do_access(1'b0, 1'b0, 6'h03, 14'h0, 14'h3A3C);
                bus.req0 = 1'b0;
            end
            begin
                @(posedge clk); #1;
                do_access(1'b1, 1'b0, 6'h09, 14'h0, 14'h0999);
                bus.req1 = 1'b0;
            end
        join
        check("t4_no_gap_handover", acc_cyc[1], acc_cyc[0] + 1);
        repeat (3) @(posedge clk);
        #1;

        // T5: write then read back through requester 1
        do_access(1'b1, 1'b1, 6'h3F, 14'h02A5, 14'h0);
        do_access(1'b1, 1'b0, 6'h3F, 14'h0, 14'h02A5);
        bus.req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // T6: reset pulse while requester 1's read is in flight
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'h09;
        @(negedge clk);
        @(negedge clk);
        check("t6_gnt1_before", {31'b0, bus.gnt1}, 32'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        check("t6_gnt1_async_drop", {31'b0, bus.gnt1},    32'd0);
        check("t6_rvalid1_in_rst",  {31'b0, bus.rvalid1}, 32'd0);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'h30; bus.wdata0 = 14'h0123;
        bus.we1 = 1'b1; bus.addr1 = 6'h31; bus.wdata1 = 14'h0321;
        #1;
        rstn = 1'b0;
        @(negedge clk);
        check("t6_rvalid1_dropped", {31'b0, bus.rvalid1}, 32'd0);
        @(negedge clk);
        check("t6_gnt0_first", {31'b0, bus.gnt0}, 32'd1);
        check("t6_gnt1_wait",  {31'b0, bus.gnt1}, 32'd0);
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
